// File: rtl/ps2_rx_core_if.sv
// Host-side bus of the PS/2 receiver: FIFO read port, status pulses and interrupt.
interface ps2_rx_core_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             rd_i;
    logic [7:0]       dat_o;
    logic             empty_o;
    logic             full_o;
    logic [CNT_W-1:0] cnt_o;
    logic             err_par_o;
    logic             err_frm_o;
    logic             ovf_o;
    logic             irq_o;

    modport slave (
        input  rd_i,
        output dat_o, empty_o, full_o, cnt_o, err_par_o, err_frm_o, ovf_o, irq_o
    );

    modport master (
        output rd_i,
        input  dat_o, empty_o, full_o, cnt_o, err_par_o, err_frm_o, ovf_o, irq_o
    );
endinterface

// File: rtl/ps2_rx_core.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit deframer with
// parity/stop/timeout checking, show-ahead receive FIFO and level interrupt.
module ps2_rx_core #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          en_i,
    input  logic          irq_en_i,
    input  logic          ps2_clk_i,
    input  logic          ps2_dat_i,
    ps2_rx_core_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FC_W  = $clog2(FILT_LEN) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Line index 0 is the PS/2 clock, index 1 the PS/2 data.
    logic [1:0]            raw;
    logic [1:0]            s1_q, s2_q, filt_q;
    logic [1:0][FC_W-1:0]  fcnt_q;
    logic                  clk_prev_q;
    logic                  fall;

    assign raw = {ps2_dat_i, ps2_clk_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q       <= 2'b11;
            s2_q       <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            s1_q       <= raw;
            s2_q       <= s1_q;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FC_W'(FILT_LEN - 1)) begin
                    filt_q[i] <= s2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];

    state_t           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_ok_q, par_ok_d;
    logic [TO_W-1:0]  tmo_q, tmo_d;
    logic             push_q, push_d;
    logic             err_par_q, err_par_d;
    logic             err_frm_q, err_frm_d;

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        par_ok_d  = par_ok_q;
        tmo_d     = tmo_q + 1'b1;
        push_d    = 1'b0;
        err_par_d = 1'b0;
        err_frm_d = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            tmo_d   = '0;
        end else if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!filt_q[1]) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d  = {filt_q[1], shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ^{shreg_q, filt_q[1]};
                    state_d  = STOP;
                end
                STOP: begin
                    if (!filt_q[1])     err_frm_d = 1'b1;
                    else if (!par_ok_q) err_par_d = 1'b1;
                    else                push_d    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TO_W'(TIMEOUT_CYC - 1)) begin
            // Stalled frame: drop the partial byte and wait for a fresh start bit.
            err_frm_d = 1'b1;
            state_d   = IDLE;
            tmo_d     = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            par_ok_q  <= 1'b0;
            tmo_q     <= '0;
            push_q    <= 1'b0;
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            par_ok_q  <= par_ok_d;
            tmo_q     <= tmo_d;
            push_q    <= push_d;
            err_par_q <= err_par_d;
            err_frm_q <= err_frm_d;
        end
    end

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, empty, wr, rd;

    assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
    assign wr    = push_q & ~full;
    assign rd    = bus.rd_i & ~empty;

    always_comb begin
        cnt_d = cnt_q;
        case ({wr, rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem[wptr_q] <= shreg_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + 1'b1;
            if (rd) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    assign bus.dat_o     = empty ? 8'h00 : mem[rptr_q];
    assign bus.empty_o   = empty;
    assign bus.full_o    = full;
    assign bus.cnt_o     = cnt_q;
    assign bus.err_par_o = err_par_q;
    assign bus.err_frm_o = err_frm_q;
    assign bus.ovf_o     = push_q & full;
    assign bus.irq_o     = irq_en_i & ~empty;
endmodule

// File: tb/tb_ps2_rx_core.sv
// Scoreboarded bench: a frame-level model predicts bytes and error pulses,
// a monitor pops expectations whenever the DUT pulses or a read is taken.
module tb_ps2_rx_core;
    localparam int DEPTH = 8;
    localparam int FILT  = 4;
    localparam int TMO   = 200;
    localparam int HALF  = 20;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, irq_en = 1'b1;
    logic ps2_clk = 1'b1, ps2_dat = 1'b1;

    ps2_rx_core_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_rx_core #(.FIFO_DEPTH(DEPTH), .FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .irq_en_i(irq_en),
        .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_PAR = 1, EV_FRM = 2, EV_OVF = 3} ev_t;
    ev_t        evq[$];
    logic [7:0] exp_q[$];
    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_ev(input ev_t ev, input string name);
        if (evq.size() == 0) begin
            tot_cnt++;
            $display("FAIL %s: unexpected pulse, expected none", name);
        end else begin
            chk(name, int'(ev), int'(evq.pop_front()));
        end
    endtask

    // Monitor: consumes expectations when the DUT presents an event or a read.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.err_par_o) check_ev(EV_PAR, "err_par_o");
            if (bus.err_frm_o) check_ev(EV_FRM, "err_frm_o");
            if (bus.ovf_o)     check_ev(EV_OVF, "ovf_o");
            if (bus.rd_i && !bus.empty_o) begin
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL rd_data: got 0x%0h, expected empty FIFO", bus.dat_o);
                end else begin
                    chk("rd_data", int'(bus.dat_o), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, " cnt_o"},   int'(bus.cnt_o),   n);
        chk({tag, " empty_o"}, int'(bus.empty_o), int'(n == 0));
        chk({tag, " full_o"},  int'(bus.full_o),  int'(n == DEPTH));
        chk({tag, " irq_o"},   int'(bus.irq_o),   int'(irq_en && n != 0));
        chk({tag, " dat_o"},   int'(bus.dat_o),   (n != 0) ? int'(exp_q[0]) : 0);
    endtask

    // Device drives data mid-way through clock-high, host samples on the fall.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            if (glitch && i == 3) begin
                cyc(3); ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(HALF / 2 - 5);
            end else begin
                cyc(HALF / 2);
            end
            ps2_dat = bits[i];
            cyc(HALF / 2);
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        cyc(HALF / 2);
        ps2_dat = 1'b1;
        cyc(HALF / 2);
    endtask

    // kind: 0 good, 1 parity flipped, 2 stop bit 0
    task automatic frame(input logic [7:0] b, input int kind, input bit glitch, input string tag);
        logic par, stop;
        par  = ~^b;
        if (kind == 1) par = ~par;
        stop = (kind == 2) ? 1'b0 : 1'b1;
        if (en) begin
            if (!stop)                    evq.push_back(EV_FRM);
            else if (^{b, par} != 1'b1)   evq.push_back(EV_PAR);
            else if (exp_q.size() == DEPTH) evq.push_back(EV_OVF);
            else                          exp_q.push_back(b);
        end
        send_bits({stop, par, b, 1'b0}, 11, glitch);
        cyc(5);
        chk({tag, " events"}, evq.size(), 0);
        check_state(tag);
    endtask

    task automatic read(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 bus.rd_i = 1'b1;
            @(posedge clk); #1 bus.rd_i = 1'b0;
        end
        cyc(1);
        check_state(tag);
    endtask

    initial begin
        bus.rd_i = 1'b0;
        cyc(3);
        chk("reset dat_o",   int'(bus.dat_o),     0);
        chk("reset empty_o", int'(bus.empty_o),   1);
        chk("reset full_o",  int'(bus.full_o),    0);
        chk("reset cnt_o",   int'(bus.cnt_o),     0);
        chk("reset irq_o",   int'(bus.irq_o),     0);
        chk("reset pulses",  int'({bus.err_par_o, bus.err_frm_o, bus.ovf_o}), 0);
        rst_n = 1'b1;
        cyc(5);

        frame(8'h1C, 0, 1'b0, "f1c");
        read(1, "f1c_rd");
        read(1, "rd_empty");
        frame(8'h1C, 1, 1'b0, "badpar");
        frame(8'h1C, 2, 1'b0, "badstop");

        for (int i = 1; i <= 9; i++) frame(8'(i), 0, 1'b0, "fill");
        read(8, "drain");

        // Start bit plus three data bits, then the clock goes quiet.
        evq.push_back(EV_FRM);
        send_bits(11'b000_0000_0010, 4, 1'b0);
        cyc(TMO + 20);
        chk("timeout events", evq.size(), 0);
        frame(8'hF0, 0, 1'b0, "after_tmo");
        read(1, "after_tmo_rd");

        frame(8'hA5, 0, 1'b1, "glitch_frame");
        ps2_dat = 1'b0;
        cyc(4); ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(4);
        ps2_dat = 1'b1;
        cyc(TMO + 20);
        check_state("glitch_idle");

        en = 1'b0;
        frame(8'h3C, 0, 1'b0, "disabled");
        en = 1'b1;
        cyc(5);

        send_bits({2'b11, 8'h55, 1'b0}, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        evq.delete();
        chk("midrst dat_o",   int'(bus.dat_o),   0);
        chk("midrst empty_o", int'(bus.empty_o), 1);
        chk("midrst cnt_o",   int'(bus.cnt_o),   0);
        chk("midrst irq_o",   int'(bus.irq_o),   0);
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        frame(8'h77, 0, 1'b0, "post_rst");

        for (int i = 0; i < 24; i++) begin
            int r;
            r = $urandom_range(0, 9);
            irq_en = 1'($urandom_range(0, 1));
            frame(8'($urandom), (r < 7) ? 0 : ((r == 7) ? 1 : 2), 1'b0, "rand");
            if ($urandom_range(0, 1) == 1) read($urandom_range(0, 3), "rand_rd");
        end
        read(exp_q.size(), "final_drain");
        chk("final events", evq.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
